sfifo: RTL and testbench
========================

# sfifo

Single-clock, parametrised FIFO for MAC-side buffering where both producer and consumer share one clock domain. It extends the team's dual-clock FIFO interface with configurable width and depth, a selectable first-word-fall-through (FWFT) or standard read mode, a live occupancy count, a synchronous flush, and sticky overflow/underflow error flags. Storage is a register array of 2^FIFO_DEPTH words with binary read/write pointers and an occupancy counter.

## Interface
- FIFO_DEPTH, 4, address bits; capacity N = 2^FIFO_DEPTH words (legal 2..10)
- FIFO_WIDTH, 8, data word width in bits
- FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = first-word-fall-through
- CLK  in  1  single clock; all state changes on rising edge
- RST  in  1  asynchronous, active-low reset (0 = reset asserted)
- FIFO_CLEAR  in  1  synchronous flush, active-high
- FIFO_WR_ENA  in  1  write request
- FIFO_WR_DATA  in  FIFO_WIDTH  write word
- FIFO_WR_FULL  out  1  COUNT == N
- FIFO_WR_ALM_FULL  out  1  (N − COUNT) <= FIFO_WR_ALM_COUNT
- FIFO_WR_ALM_COUNT  in  FIFO_DEPTH  almost-full threshold (free slots)
- FIFO_RD_ENA  in  1  read request / pop
- FIFO_RD_DATA  out  FIFO_WIDTH  read word
- FIFO_RD_EMPTY  out  1  COUNT == 0
- FIFO_RD_ALM_EMPTY  out  1  COUNT <= FIFO_RD_ALM_COUNT
- FIFO_RD_ALM_COUNT  in  FIFO_DEPTH  almost-empty threshold (stored words)
- FIFO_COUNT  out  FIFO_DEPTH+1  stored words, 0..N
- FIFO_OVERFLOW  out  1  sticky: write attempted while full
- FIFO_UNDERFLOW  out  1  sticky: read attempted while empty

## Operation
- Reset (RST=0): wr_ptr, rd_ptr, COUNT = 0; FULL=0, EMPTY=1, ALM_EMPTY=1, OVERFLOW=0, UNDERFLOW=0; RD_DATA register = 0 (FWFT=0). ALM_FULL = (N <= WR_ALM_COUNT), normally 0. Memory contents not reset.
- Write accepted iff WR_ENA=1 and FULL=0: mem[wr_ptr] <= WR_DATA, wr_ptr+1 mod N.
- Read accepted iff RD_ENA=1 and EMPTY=0: rd_ptr+1 mod N.
- Acceptance uses flags as registered at the start of the cycle; a read on a full FIFO does not enable a same-cycle write; a write to an empty FIFO does not enable a same-cycle read.
- COUNT: +1 write only, −1 read only, unchanged for both or neither. Never exceeds N or goes below 0.
- Rejected write: data discarded, OVERFLOW <= 1. Rejected read: pointers unchanged, RD_DATA unchanged, UNDERFLOW <= 1. Both sticky until FIFO_CLEAR or reset.
- FIFO_CLEAR=1: pointers, COUNT, OVERFLOW, UNDERFLOW <= 0; highest priority over same-cycle WR_ENA/RD_ENA (both ignored, no error flagged). RD_DATA register holds its value.
- FWFT=0: on accepted read, RD_DATA <= mem[rd_ptr] at that edge; otherwise RD_DATA holds.
- FWFT=1: RD_DATA = mem[rd_ptr] whenever EMPTY=0 (value undefined when EMPTY=1); RD_ENA acknowledges/pops the presented word.
- Pointers wrap N−1 → 0 with no gap; full/empty distinguished only by COUNT.

## Timing
- All flags and COUNT are decoded from registered state; they change only on the clock edge (or asynchronously at reset).
- Write → EMPTY deasserts the cycle after the write edge; FWFT=1 data visible in that same cycle (write-to-read latency 1).
- FWFT=0 read latency: data valid one cycle after the edge sampling RD_ENA.
- Full write throughput: one word per cycle; simultaneous read+write every cycle sustained indefinitely at any 0 < COUNT < N.
- Threshold inputs are quasi-static; a change is reflected combinationally in ALM flags the same cycle.
- Reset mid-operation aborts any transfer; FIFO is empty on RST release; first accepted write is the first edge with RST=1.

## Test plan
- Defaults (4,8,FWFT=0): after reset write 0x00..0x0F on 16 cycles -> FULL=1, COUNT=16, ALM_FULL asserted at COUNT=15 with WR_ALM_COUNT=1; then read 16 -> RD_DATA 0x00..0x0F in order, 1-cycle latency, EMPTY=1 after last.
- Full FIFO, write 0xAA -> OVERFLOW=1, COUNT stays 16, 0xAA never read; empty FIFO, read -> UNDERFLOW=1, RD_DATA unchanged; FIFO_CLEAR -> both flags 0, COUNT=0.
- FWFT=1: write 0x5A into empty FIFO -> next cycle EMPTY=0, RD_DATA=0x5A without RD_ENA; RD_ENA pop -> EMPTY=1 following cycle.
- Pointer wrap: 1000 cycles simultaneous read+write of an incrementing pattern at COUNT=8 -> COUNT constant 8, data order preserved, no error flags; repeat with FIFO_WIDTH=32, FIFO_DEPTH=6.
- Boundaries: COUNT=16 with WR_ENA+RD_ENA -> read accepted, write rejected, COUNT=15, OVERFLOW=1; COUNT=0 with both -> write accepted, UNDERFLOW=1, COUNT=1; FIFO_CLEAR with both -> COUNT=0, no flags.
- Drive RST=0 asynchronously mid-burst at COUNT=9 -> COUNT=0, EMPTY=1, FULL=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/sfifo.sv
// Single-clock FIFO with register-array storage, binary pointers and an occupancy counter.
// Supports standard (registered) or first-word-fall-through read, flush and sticky error flags.
module sfifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int FWFT       = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FIFO_CLEAR,
  input  logic                  FIFO_WR_ENA,
  input  logic [FIFO_WIDTH-1:0] FIFO_WR_DATA,
  output logic                  FIFO_WR_FULL,
  output logic                  FIFO_WR_ALM_FULL,
  input  logic [FIFO_DEPTH-1:0] FIFO_WR_ALM_COUNT,
  input  logic                  FIFO_RD_ENA,
  output logic [FIFO_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_RD_EMPTY,
  output logic                  FIFO_RD_ALM_EMPTY,
  input  logic [FIFO_DEPTH-1:0] FIFO_RD_ALM_COUNT,
  output logic [FIFO_DEPTH:0]   FIFO_COUNT,
  output logic                  FIFO_OVERFLOW,
  output logic                  FIFO_UNDERFLOW
);

  localparam int unsigned            N       = 2 ** FIFO_DEPTH;
  localparam logic [FIFO_DEPTH:0]    N_WORDS = (FIFO_DEPTH + 1)'(N);
  localparam logic [FIFO_DEPTH-1:0]  PTR_ONE = FIFO_DEPTH'(1);
  localparam logic [FIFO_DEPTH:0]    CNT_ONE = (FIFO_DEPTH + 1)'(1);

  logic [FIFO_WIDTH-1:0] mem_q [N];

  logic [FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [FIFO_DEPTH:0]   free_slots;

  // Acceptance looks only at registered occupancy, so a same-cycle pop never frees room for a push.
  assign full       = (count_q == N_WORDS);
  assign empty      = (count_q == '0);
  assign wr_acc     = FIFO_WR_ENA && !full && !FIFO_CLEAR;
  assign rd_acc     = FIFO_RD_ENA && !empty && !FIFO_CLEAR;
  assign free_slots = N_WORDS - count_q;

  assign FIFO_WR_FULL      = full;
  assign FIFO_RD_EMPTY     = empty;
  assign FIFO_WR_ALM_FULL  = (free_slots <= {1'b0, FIFO_WR_ALM_COUNT});
  assign FIFO_RD_ALM_EMPTY = (count_q <= {1'b0, FIFO_RD_ALM_COUNT});
  assign FIFO_COUNT        = count_q;
  assign FIFO_OVERFLOW     = overflow_q;
  assign FIFO_UNDERFLOW    = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (FIFO_CLEAR) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (FIFO_WR_ENA && full)  overflow_d  = 1'b1;
      if (FIFO_RD_ENA && empty) underflow_d = 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset; stale words are never observable through the flags.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem_q[wr_ptr_q] <= FIFO_WR_DATA;
  end

  if (FWFT != 0) begin : g_fwft
    assign FIFO_RD_DATA = mem_q[rd_ptr_q];
  end else begin : g_std
    logic [FIFO_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
      rd_data_d = rd_data_q;
      if (rd_acc) rd_data_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) rd_data_q <= '0;
      else      rd_data_q <= rd_data_d;
    end

    assign FIFO_RD_DATA = rd_data_q;
  end

endmodule

// File: tb/tb_sfifo.sv
// Bench for sfifo: three instances (default, FWFT, 64x32) checked against a queue-based FIFO model
// plus a hand-written vector table for the fill / overflow / drain / underflow / flush walk.
module tb_sfifo;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST;

  localparam logic [3:0] AB_ALM = 4'd1;
  localparam logic [5:0] C_WALM = 6'd3;
  localparam logic [5:0] C_RALM = 6'd5;

  logic        a_clear, a_wr, a_rd;
  logic [7:0]  a_wdata, a_rdata;
  logic        a_full, a_afull, a_empty, a_aempty, a_ovf, a_unf;
  logic [4:0]  a_count;

  logic        b_clear, b_wr, b_rd;
  logic [7:0]  b_wdata, b_rdata;
  logic        b_full, b_afull, b_empty, b_aempty, b_ovf, b_unf;
  logic [4:0]  b_count;

  logic        c_clear, c_wr, c_rd;
  logic [31:0] c_wdata, c_rdata;
  logic        c_full, c_afull, c_empty, c_aempty, c_ovf, c_unf;
  logic [6:0]  c_count;

  sfifo #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .FWFT(0)) u_a (
    .CLK(CLK), .RST(RST), .FIFO_CLEAR(a_clear),
    .FIFO_WR_ENA(a_wr), .FIFO_WR_DATA(a_wdata), .FIFO_WR_FULL(a_full),
    .FIFO_WR_ALM_FULL(a_afull), .FIFO_WR_ALM_COUNT(AB_ALM),
    .FIFO_RD_ENA(a_rd), .FIFO_RD_DATA(a_rdata), .FIFO_RD_EMPTY(a_empty),
    .FIFO_RD_ALM_EMPTY(a_aempty), .FIFO_RD_ALM_COUNT(AB_ALM),
    .FIFO_COUNT(a_count), .FIFO_OVERFLOW(a_ovf), .FIFO_UNDERFLOW(a_unf)
  );

  sfifo #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .FWFT(1)) u_b (
    .CLK(CLK), .RST(RST), .FIFO_CLEAR(b_clear),
    .FIFO_WR_ENA(b_wr), .FIFO_WR_DATA(b_wdata), .FIFO_WR_FULL(b_full),
    .FIFO_WR_ALM_FULL(b_afull), .FIFO_WR_ALM_COUNT(AB_ALM),
    .FIFO_RD_ENA(b_rd), .FIFO_RD_DATA(b_rdata), .FIFO_RD_EMPTY(b_empty),
    .FIFO_RD_ALM_EMPTY(b_aempty), .FIFO_RD_ALM_COUNT(AB_ALM),
    .FIFO_COUNT(b_count), .FIFO_OVERFLOW(b_ovf), .FIFO_UNDERFLOW(b_unf)
  );

  sfifo #(.FIFO_DEPTH(6), .FIFO_WIDTH(32), .FWFT(0)) u_c (
    .CLK(CLK), .RST(RST), .FIFO_CLEAR(c_clear),
    .FIFO_WR_ENA(c_wr), .FIFO_WR_DATA(c_wdata), .FIFO_WR_FULL(c_full),
    .FIFO_WR_ALM_FULL(c_afull), .FIFO_WR_ALM_COUNT(C_WALM),
    .FIFO_RD_ENA(c_rd), .FIFO_RD_DATA(c_rdata), .FIFO_RD_EMPTY(c_empty),
    .FIFO_RD_ALM_EMPTY(c_aempty), .FIFO_RD_ALM_COUNT(C_RALM),
    .FIFO_COUNT(c_count), .FIFO_OVERFLOW(c_ovf), .FIFO_UNDERFLOW(c_unf)
  );

  typedef struct {
    logic        clear;
    logic        wr;
    logic        rd;
    logic [31:0] data;
    int          count;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t        vecs [35];
  int          cur;
  logic [31:0] sb [$];
  logic        m_ovf, m_unf;
  logic [31:0] m_rdata [3];
  int          checks, errors;

  int          d_count;
  logic        d_full, d_empty, d_afull, d_aempty, d_ovf, d_unf;
  logic [31:0] d_rdata;

  // Presents the outputs of whichever instance is currently under test.
  always_comb begin
    d_count  = 0;
    d_full   = 1'b0;
    d_empty  = 1'b0;
    d_afull  = 1'b0;
    d_aempty = 1'b0;
    d_ovf    = 1'b0;
    d_unf    = 1'b0;
    d_rdata  = '0;
    case (cur)
      0: begin
        d_count = int'(a_count); d_full = a_full; d_empty = a_empty; d_afull = a_afull;
        d_aempty = a_aempty; d_ovf = a_ovf; d_unf = a_unf; d_rdata = {24'd0, a_rdata};
      end
      1: begin
        d_count = int'(b_count); d_full = b_full; d_empty = b_empty; d_afull = b_afull;
        d_aempty = b_aempty; d_ovf = b_ovf; d_unf = b_unf; d_rdata = {24'd0, b_rdata};
      end
      2: begin
        d_count = int'(c_count); d_full = c_full; d_empty = c_empty; d_afull = c_afull;
        d_aempty = c_aempty; d_ovf = c_ovf; d_unf = c_unf; d_rdata = c_rdata;
      end
      default: ;
    endcase
  end

  function automatic int cap(input int i);
    return (i == 2) ? 64 : 16;
  endfunction

  function automatic int walm(input int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic int ralm(input int i);
    return (i == 2) ? 5 : 1;
  endfunction

  function automatic vec_t mkvec(input logic c, input logic w, input logic r, input logic [31:0] d,
                                 input int n, input logic f, input logic e, input logic o,
                                 input logic u);
    vec_t v;
    v.clear = c; v.wr = w; v.rd = r; v.data = d; v.count = n;
    v.full = f; v.empty = e; v.ovf = o; v.unf = u;
    return v;
  endfunction

  task automatic cmp(input string what, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (t=%0t)", what, got, exp, $time);
    end
  endtask

  task automatic idleAll();
    a_clear = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_wdata = '0;
    b_clear = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_wdata = '0;
    c_clear = 1'b0; c_wr = 1'b0; c_rd = 1'b0; c_wdata = '0;
  endtask

  // Drives one cycle on the current instance and advances the model past that edge.
  task automatic applyStimulus(input logic clear, input logic wr, input logic rd,
                               input logic [31:0] data);
    int          cnt;
    logic        wacc, racc;
    logic [31:0] wd;
    @(negedge CLK);
    idleAll();
    wd = (cur == 2) ? data : {24'd0, data[7:0]};
    case (cur)
      0: begin a_clear = clear; a_wr = wr; a_rd = rd; a_wdata = data[7:0]; end
      1: begin b_clear = clear; b_wr = wr; b_rd = rd; b_wdata = data[7:0]; end
      default: begin c_clear = clear; c_wr = wr; c_rd = rd; c_wdata = data; end
    endcase
    cnt  = sb.size();
    wacc = wr && !clear && (cnt < cap(cur));
    racc = rd && !clear && (cnt > 0);
    @(posedge CLK);
    #1;
    if (clear) begin
      sb.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (wr && !wacc) m_ovf = 1'b1;
      if (rd && !racc) m_unf = 1'b1;
      if (racc) m_rdata[cur] = sb.pop_front();
      if (wacc) sb.push_back(wd);
    end
  endtask

  task automatic checkOutput(input string tag);
    int cnt;
    cnt = sb.size();
    cmp({tag, ".count"},  32'(d_count),  32'(cnt));
    cmp({tag, ".full"},   32'(d_full),   32'(cnt == cap(cur)));
    cmp({tag, ".empty"},  32'(d_empty),  32'(cnt == 0));
    cmp({tag, ".afull"},  32'(d_afull),  32'((cap(cur) - cnt) <= walm(cur)));
    cmp({tag, ".aempty"}, 32'(d_aempty), 32'(cnt <= ralm(cur)));
    cmp({tag, ".ovf"},    32'(d_ovf),    32'(m_ovf));
    cmp({tag, ".unf"},    32'(d_unf),    32'(m_unf));
    if (cur == 1) begin
      if (cnt > 0) cmp({tag, ".rdata"}, d_rdata, sb[0]);
    end else begin
      cmp({tag, ".rdata"}, d_rdata, m_rdata[cur]);
    end
  endtask

  task automatic resetModel();
    sb.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    for (int i = 0; i < 3; i++) m_rdata[i] = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cur    = 0;
    RST    = 1'b0;
    idleAll();
    resetModel();

    for (int i = 0; i < 16; i++)
      vecs[i] = mkvec(1'b0, 1'b1, 1'b0, 32'(i), i + 1, (i == 15), 1'b0, 1'b0, 1'b0);
    vecs[16] = mkvec(1'b0, 1'b1, 1'b0, 32'hAA, 16, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++)
      vecs[17 + i] = mkvec(1'b0, 1'b0, 1'b1, 32'h0, 15 - i, 1'b0, (i == 15), 1'b1, 1'b0);
    vecs[33] = mkvec(1'b0, 1'b0, 1'b1, 32'h0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    vecs[34] = mkvec(1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cur = i;
      #1 checkOutput("reset");
    end

    // Fill / overflow / drain / underflow / flush on the default instance.
    cur = 0;
    for (int i = 0; i < 35; i++) begin
      applyStimulus(vecs[i].clear, vecs[i].wr, vecs[i].rd, vecs[i].data);
      checkOutput("table");
      cmp("table.count", 32'(d_count), 32'(vecs[i].count));
      cmp("table.full",  32'(d_full),  32'(vecs[i].full));
      cmp("table.empty", 32'(d_empty), 32'(vecs[i].empty));
      cmp("table.ovf",   32'(d_ovf),   32'(vecs[i].ovf));
      cmp("table.unf",   32'(d_unf),   32'(vecs[i].unf));
      if (i >= 17 && i <= 32) cmp("table.rdata", d_rdata, 32'(i - 17));
    end

    // Simultaneous read+write at the full and empty boundaries, then flush with both requests.
    for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h30 + 32'(k));
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h99);
    checkOutput("bnd_full_rw");
    cmp("bnd_full_rw.count", 32'(d_count), 32'd15);
    cmp("bnd_full_rw.ovf", 32'(d_ovf), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h55);
    checkOutput("bnd_clear_rw");
    cmp("bnd_clear_rw.count", 32'(d_count), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h42);
    checkOutput("bnd_empty_rw");
    cmp("bnd_empty_rw.count", 32'(d_count), 32'd1);
    cmp("bnd_empty_rw.unf", 32'(d_unf), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    // Sustained read+write at COUNT=8 wraps the pointers many times.
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'(k));
    for (int k = 0; k < 1000; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'(k + 8));
      checkOutput("wrapA");
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    // First-word-fall-through instance.
    cur = 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h5A);
    checkOutput("fwft_wr");
    cmp("fwft_wr.rdata", d_rdata, 32'h5A);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("fwft_hold");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("fwft_pop");
    cmp("fwft_pop.empty", 32'(d_empty), 32'd1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, (k < 4), (k >= 1), 32'h10 + 32'(k));
      checkOutput("fwft_seq");
    end

    // Wide, deep instance: wrap at COUNT=8, then fill to full and overflow.
    cur = 2;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'hA5A5_0000 + 32'(k));
    for (int k = 0; k < 1000; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h1000_0000 + 32'(k) * 32'h0001_0001);
      checkOutput("wrapC");
    end
    for (int k = 0; k < 57; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'hC000_0000 + 32'(k));
    checkOutput("fillC");
    cmp("fillC.full", 32'(d_full), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    checkOutput("ovfC");

    // Asynchronous reset in the middle of a write burst.
    cur = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 9; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h60 + 32'(k));
    @(negedge CLK);
    a_wr = 1'b1;
    a_wdata = 8'hEE;
    #2 RST = 1'b0;
    resetModel();
    #1;
    checkOutput("async_rst");
    cmp("async_rst.count", 32'(d_count), 32'd0);
    cmp("async_rst.empty", 32'(d_empty), 32'd1);
    cmp("async_rst.full", 32'(d_full), 32'd0);
    idleAll();
    @(posedge CLK);
    #2 RST = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h77);
    checkOutput("post_rst_wr");
    cmp("post_rst_wr.count", 32'(d_count), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("post_rst_rd");
    cmp("post_rst_rd.rdata", d_rdata, 32'h77);

    @(negedge CLK);
    idleAll();
    repeat (2) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
